// File: rtl/mips16_pkg.sv
// mips16_pkg: constants shared by the multi-cycle controller, the datapath
// and the testbench.
//   - state_t      : controller state encodings (also visible on the debug port)
//   - OP_*         : 4-bit opcodes found in ir[15:12]; HALT_WORD stops the core
//   - ALU_*        : {ainvert, binvert, op[1:0]} codes for the shared ALU
//   - SRC_B_*      : ALU input B mux select encodings
package mips16_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC_R = 3'd3,
        S_EXEC_I = 3'd4,
        S_BRANCH = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_TWO    = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

endpackage

// File: rtl/mips16_alu_decode.sv
// mips16_alu_decode: pure combinational opcode -> ALU control mapping.
// Ports:
//   opcode      in  4  ir[15:12]
//   alu_control out 4  {ainvert, binvert, op[1:0]}
// Anything that is not an R-type opcode maps to ADD, which is exactly what
// addi needs, so the controller can use this output unconditionally in WB.
module mips16_alu_decode
    import mips16_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (opcode)
            OP_ADD:  alu_control = ALU_ADD;
            OP_SUB:  alu_control = ALU_SUB;
            OP_AND:  alu_control = ALU_AND;
            OP_OR:   alu_control = ALU_OR;
            OP_NOR:  alu_control = ALU_NOR;
            OP_NAND: alu_control = ALU_NAND;
            OP_SLT:  alu_control = ALU_SLT;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips16_mc_controller.sv
// mips16_mc_controller: multi-cycle sequencer for the 16-bit MIPS datapath.
// Time-shares one ALU between PC+2, branch-target computation and execution.
// Ports:
//   clock, reset_n             clock (flops update on its falling edge),
//                              asynchronous active-low reset
//   run_en                     allows a new instruction at a boundary
//   ir, zero                   instruction register and ALU zero flag
//   ir_write, pc_write, pc_src, target_write, reg_write   datapath strobes
//   alu_src_a, alu_src_b, alu_control, reg_dst            datapath selects
//   instr_done, halted, retired_count, state              status / debug
// Outputs are decoded from the current state (and ir/zero where needed), so
// an asynchronous reset forces every strobe low immediately.
module mips16_mc_controller
    import mips16_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run_en,
    input  logic [15:0] ir,
    input  logic        zero,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        target_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_control,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        instr_done,
    output logic        halted,
    output logic [15:0] retired_count,
    output logic [2:0]  state
);

    state_t      state_reg;
    state_t      state_next;
    state_t      boundary_state;
    logic [15:0] retired_count_reg;
    logic [3:0]  opcode;
    logic [3:0]  alu_rtype;

    assign opcode         = ir[15:12];
    assign boundary_state = run_en ? S_FETCH : S_IDLE;
    assign state          = state_reg;
    assign retired_count  = retired_count_reg;

    mips16_alu_decode u_alu_decode (
        .opcode      (opcode),
        .alu_control (alu_rtype)
    );

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Wraps naturally at 16 bits.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_count_reg <= 16'h0000;
        end else if (instr_done) begin
            retired_count_reg <= retired_count_reg + 16'd1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        target_write = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRC_B_REG;
        alu_control  = ALU_AND;
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        instr_done   = 1'b0;
        halted       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run_en) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // PC <= PC + 2 while the instruction is latched.
                ir_write    = 1'b1;
                alu_src_b   = SRC_B_TWO;
                alu_control = ALU_ADD;
                pc_write    = 1'b1;
                state_next  = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively for every opcode;
                // the ALU is idle otherwise in this cycle.
                alu_src_b    = SRC_B_IMM_SH;
                alu_control  = ALU_ADD;
                target_write = 1'b1;
                if (ir == HALT_WORD) begin
                    state_next = S_HALT;
                end else if (opcode <= OP_SLT) begin
                    state_next = S_EXEC_R;
                end else if (opcode == OP_ADDI) begin
                    state_next = S_EXEC_I;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    state_next = S_BRANCH;
                end else begin
                    instr_done = 1'b1;
                    state_next = boundary_state;
                end
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRC_B_REG;
                alu_control = alu_rtype;
                state_next  = S_WB;
            end
            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRC_B_IMM;
                alu_control = ALU_ADD;
                state_next  = S_WB;
            end
            S_WB: begin
                // ALU selects held from the EXEC state; the decoder already
                // yields ADD for addi.
                alu_src_a   = 1'b1;
                alu_control = alu_rtype;
                reg_write   = 1'b1;
                instr_done  = 1'b1;
                if (opcode == OP_ADDI) begin
                    alu_src_b = SRC_B_IMM;
                    reg_dst   = 1'b0;
                end else begin
                    alu_src_b = SRC_B_REG;
                    reg_dst   = 1'b1;
                end
                state_next = boundary_state;
            end
            S_BRANCH: begin
                // A - B drives the zero flag; the PC loads the precomputed target.
                alu_src_a   = 1'b1;
                alu_src_b   = SRC_B_REG;
                alu_control = ALU_SUB;
                pc_src      = 1'b1;
                pc_write    = (opcode == OP_BEQ) ? zero : ~zero;
                instr_done  = 1'b1;
                state_next  = boundary_state;
            end
            S_HALT: begin
                halted = 1'b1;
            end
        endcase
    end

endmodule
